// File: rtl/ctrl_pila.sv
// rtl/ctrl_pila.sv - return-address stack sequencer for call/ret/iret/irq
module ctrl_pila #(
  parameter int             AW      = 10,
  parameter int             DEPTH   = 64,
  parameter int             DW      = 7,
  parameter logic [AW-1:0]  IRQ_VEC = AW'(1000)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic          call,
  input  logic          ret,
  input  logic          iret,
  input  logic          irq,
  input  logic          irq_en,
  input  logic          clr_err,
  output logic [AW-1:0] ret_addr,
  output logic [1:0]    pc_sel,
  output logic          stall,
  output logic          irq_ack,
  output logic          in_isr,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic [1:0]    err_code
);

  localparam int AI = $clog2(DEPTH);

  localparam logic [1:0] SEL_CORE = 2'd0;
  localparam logic [1:0] SEL_RET  = 2'd1;
  localparam logic [1:0] SEL_IRQ  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  localparam logic [1:0] E_OVF  = 2'd1;
  localparam logic [1:0] E_UNF  = 2'd2;
  localparam logic [1:0] E_IRET = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_ISR, S_ERR} state_t;

  state_t        state, state_n;
  logic [AW-1:0] mem [DEPTH];
  logic [AI-1:0] top_idx;
  logic          push, pop;
  logic [AW-1:0] push_val;
  logic [1:0]    err_n;

  // Index wraps so depth==DEPTH maps to the last slot.
  assign top_idx  = depth[AI-1:0] - AI'(1);
  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign ret_addr = empty ? '0 : mem[top_idx];
  assign in_isr   = (state == S_ISR);

  // Requests are resolved in priority order; the failing op never touches the stack.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    push_val = pc;
    pc_sel   = SEL_CORE;
    irq_ack  = 1'b0;
    stall    = 1'b0;
    state_n  = state;
    err_n    = err_code;
    case (state)
      S_ERR: begin
        stall  = 1'b1;
        pc_sel = SEL_HOLD;
        if (clr_err) begin
          state_n = S_RUN;
          err_n   = 2'd0;
        end
      end
      default: begin
        if (state == S_RUN && irq && irq_en) begin
          if (!full) begin
            push    = 1'b1;
            pc_sel  = SEL_IRQ;
            irq_ack = 1'b1;
            state_n = S_ISR;
          end else begin
            state_n = S_ERR;
            err_n   = E_OVF;
          end
        end else if (iret) begin
          if (state == S_RUN) begin
            state_n = S_ERR;
            err_n   = E_IRET;
          end else if (empty) begin
            state_n = S_ERR;
            err_n   = E_UNF;
          end else begin
            pop     = 1'b1;
            pc_sel  = SEL_RET;
            state_n = S_RUN;
          end
        end else if (ret) begin
          if (empty) begin
            state_n = S_ERR;
            err_n   = E_UNF;
          end else begin
            pop    = 1'b1;
            pc_sel = SEL_RET;
          end
        end else if (call) begin
          if (!full) begin
            push     = 1'b1;
            push_val = pc + AW'(1);
          end else begin
            state_n = S_ERR;
            err_n   = E_OVF;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RUN;
      depth    <= '0;
      err_code <= 2'd0;
    end else begin
      state    <= state_n;
      err_code <= err_n;
      if (push)
        depth <= depth + DW'(1);
      else if (pop)
        depth <= depth - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[depth[AI-1:0]] <= push_val;
  end

endmodule
